seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle signed integer divider that produces the 64-bit Z result for the datapath's div instruction.
- Zlow holds the quotient and Zhigh holds the remainder; the datapath moves them to LO and HI.
- Uses a non-restoring algorithm, one quotient bit per clock.
- Start/done handshake with the control unit.

Parameters:
- WIDTH, 32, operand width in bits; zout is 2*WIDTH bits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous reset, active-low: clear=0 at a rising edge resets the block.
- start  input  1  request a divide; sampled only in IDLE.
- dividend  input  WIDTH  numerator (two's complement); sampled on the edge that accepts start.
- divisor  input  WIDTH  denominator (two's complement); sampled on the same edge.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; zout is valid from this cycle onward.
- zout  output  2*WIDTH  {remainder, quotient}; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with zout.

Behaviour:
- Reset: one clock is synchronous and active-low. clear=0 at a rising edge resets the block:
  - state goes to IDLE;
  - busy=0, done=0, zout=0, div_by_zero=0;
  - internal accumulators are cleared.
- Reset mid-operation aborts the divide with no result. Reset has priority over every other input.
- States:
  - IDLE: on start=1 at edge k, latch operands and record the signs → PREP.
  - PREP: take unsigned magnitudes of both operands, clear the partial remainder, load the iteration counter with WIDTH → ITER.
  - ITER: non-restoring step each cycle:
    - shift {P,Q} left by 1;
    - P = P − |D| if P ≥ 0, else P = P + |D|;
    - Q[0] = ~P[sign];
    - decrement the counter; after the WIDTH-th step → FIX.
  - FIX:
    - if P < 0, add |D| to P (restore);
    - negate Q if the operand signs differ;
    - negate P if the dividend is negative;
    - load zout, set div_by_zero → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Latency:
  - fixed; done rises after edge k+WIDTH+2, i.e. 34 clocks for WIDTH=32, independent of operand values;
  - a new start is accepted at the edge that leaves DONE (back-to-back allowed).
- busy=1 in PREP, ITER and FIX; busy=0 in DONE and IDLE.
- start while busy is ignored; operands are not re-sampled.
- Semantics:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - dividend = q*divisor + r.
- Arithmetic width: magnitudes are WIDTH-bit unsigned, so 2^(WIDTH−1) is representable; the partial remainder is WIDTH+1 bits.
- Overflow: most-negative / −1 gives quotient = most-negative (wraps), remainder = 0, no flag.
- Divide by zero:
  - full latency still applies;
  - FIX overrides the result: quotient = all ones, remainder = original dividend, div_by_zero=1.
- zout and div_by_zero change only in FIX or on reset. During busy they keep the previous result.

Optional Feature:
- Macro DIV_UNSIGNED_SEL_EN.
- Defined:
  - adds input port div_unsigned (1 bit), sampled together with start;
  - when div_unsigned=1, operands are treated as unsigned and FIX skips all sign corrections;
  - divide by zero then gives quotient = all ones, remainder = dividend.
- Undefined:
  - the port is absent and all divides are signed;
  - latency is identical in both builds.

Test Plan:
- 18/4: dividend=0x00000012, divisor=0x00000004, start pulse → done exactly 34 clocks later; zout=0x00000002_00000004, div_by_zero=0.
- Signed mixes:
  - −7/2 → zout=0xFFFFFFFF_FFFFFFFD;
  - 7/−2 → zout=0x00000001_FFFFFFFD;
  - −7/−2 → zout=0xFFFFFFFF_00000003.
- Zero divisor: 100/0 → zout=0x00000064_FFFFFFFF, div_by_zero=1 with done; the next valid divide clears div_by_zero.
- Overflow: 0x80000000 / 0xFFFFFFFF → zout=0x00000000_80000000, div_by_zero=0.
- Handshake and reset:
  - pulse start again at cycle 5 of a busy divide → ignored; the first result is unchanged;
  - drive clear=0 at cycle 10 of a divide → next cycle busy=0, done=0, zout=0, and no done follows;
  - back-to-back starts at the DONE edge both complete correctly.
- With DIV_UNSIGNED_SEL_EN: div_unsigned=1, 0xFFFFFFFE/2 → zout=0x00000000_7FFFFFFF. With div_unsigned=0 the same operands → zout=0x00000000_FFFFFFFF.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle signed non-restoring divider: one quotient bit per clock, zout = {remainder, quotient}.
// Optional build macro DIV_UNSIGNED_SEL_EN adds a per-divide unsigned select input.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
`ifdef DIV_UNSIGNED_SEL_EN
  input  logic                 div_unsigned,
`endif
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   zout,
  output logic                 div_by_zero,
  output logic [2:0]           fsm_state
);

  // Handshake: start is taken on an edge where the block is in IDLE or DONE;
  // busy covers PREP/ITER/FIX, done pulses for the single DONE cycle and zout
  // stays valid until the FIX of the next accepted divide.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   p_reg;
  logic             sign_a;
  logic             sign_d;
  logic [CW-1:0]    cnt;
  logic             uns_in;
  logic             accept;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_UNSIGNED_SEL_EN
  assign uns_in = div_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign busy      = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!clear) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_PREP;
      S_PREP:  next_state = S_ITER;
      S_ITER:  if (cnt == CW'(1)) next_state = S_FIX;
      S_FIX:   next_state = S_DONE;
      S_DONE:  next_state = start ? S_PREP : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The partial remainder stays within [-|D|, |D|) after each step, so WIDTH+1
  // bits hold it even though the shifted intermediate may wrap.
  always_comb begin
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    p_step  = p_reg[WIDTH] ? (p_shift + {1'b0, mag_d}) : (p_shift - {1'b0, mag_d});
    p_fix   = p_reg[WIDTH] ? (p_reg + {1'b0, mag_d}) : p_reg;
    q_fix   = (sign_a ^ sign_d) ? (~q_reg + 1'b1) : q_reg;
    r_fix   = sign_a ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      a_reg       <= '0;
      mag_d       <= '0;
      q_reg       <= '0;
      p_reg       <= '0;
      sign_a      <= 1'b0;
      sign_d      <= 1'b0;
      cnt         <= '0;
      zout        <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      // Signs are recorded as zero for unsigned divides, which disables every correction.
      a_reg  <= dividend;
      q_reg  <= dividend;
      mag_d  <= divisor;
      sign_a <= dividend[WIDTH-1] & ~uns_in;
      sign_d <= divisor[WIDTH-1] & ~uns_in;
    end else begin
      case (state)
        S_PREP: begin
          q_reg <= sign_a ? (~q_reg + 1'b1) : q_reg;
          mag_d <= sign_d ? (~mag_d + 1'b1) : mag_d;
          p_reg <= '0;
          cnt   <= CW'(WIDTH);
        end
        S_ITER: begin
          p_reg <= p_step;
          q_reg <= {q_reg[WIDTH-2:0], ~p_step[WIDTH]};
          cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          if (mag_d == '0) begin
            zout        <= {a_reg, {WIDTH{1'b1}}};
            div_by_zero <= 1'b1;
          end else begin
            zout        <= {r_fix, q_fix};
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model, per-cycle compare, literal test-plan cases.
module tb_seq_divider;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
`ifdef DIV_UNSIGNED_SEL_EN
  logic           div_unsigned = 1'b0;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] zout;
  logic           div_by_zero;
  logic [2:0]     fsm_state;

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
`ifdef DIV_UNSIGNED_SEL_EN
    .div_unsigned(div_unsigned),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .zout        (zout),
    .div_by_zero (div_by_zero),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: {div_by_zero, remainder, quotient} from plain integer division.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] d, input bit uns);
    longint la, ld, q, r;
    if (d == '0) return {1'b1, a, {W{1'b1}}};
    if (uns) begin
      la = longint'({32'b0, a});
      ld = longint'({32'b0, d});
    end else begin
      la = longint'($signed(a));
      ld = longint'($signed(d));
    end
    q = la / ld;
    r = la % ld;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  function automatic bit cur_uns();
`ifdef DIV_UNSIGNED_SEL_EN
    return div_unsigned;
`else
    return 1'b0;
`endif
  endfunction

  // scoreboard: results of accepted divides awaiting their done
  logic [2*W:0]   exp_q[$];
  int             remaining = 0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic           exp_dbz = 1'b0;
  logic [2*W-1:0] exp_zout = '0;
  bit             checking = 1'b0;

  always @(posedge clock) begin
    if (!clear) begin
      remaining = 0;
      exp_done  = 1'b0;
      exp_zout  = '0;
      exp_dbz   = 1'b0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0 && exp_q.size() > 0) begin
          {exp_dbz, exp_zout} = exp_q.pop_front();
          exp_done = 1'b1;
        end
      end else if (start) begin
        exp_q.push_back(ref_div(dividend, divisor, cur_uns()));
        remaining = W + 2;
      end
    end
    exp_busy = (remaining > 0);
  end

  always @(negedge clock) begin
    if (checking) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("zout", zout, exp_zout);
      check("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
    end
  end

  // driver: one divide; returns in the DONE cycle
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] d, input bit uns,
                         input bit b2b, input int poke_at,
                         output logic [2*W-1:0] z, output logic f, output int lat);
    if (!b2b) begin
      @(posedge clock);
      #1;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = d;
`ifdef DIV_UNSIGNED_SEL_EN
    div_unsigned = uns;
`endif
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    while (!done && lat < 100) begin
      start = (lat == poke_at);
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 64'(done), 64'd1);
    z = zout;
    f = div_by_zero;
  endtask

  task automatic lit_div(input string name, input logic [W-1:0] a, input logic [W-1:0] d,
                         input bit uns, input bit b2b, input int poke_at,
                         input logic [2*W-1:0] want, input logic want_f);
    logic [2*W-1:0] z;
    logic           f;
    int             lat;
    run_div(a, d, uns, b2b, poke_at, z, f, lat);
    check({name, "_zout"}, z, want);
    check({name, "_dbz"}, 64'(f), 64'(want_f));
    check({name, "_latency"}, 64'(lat), 64'(W + 2));
  endtask

  initial begin
    logic [2*W-1:0] z;
    logic           f;
    int             lat;
    int             dn;
    logic [W-1:0]   a;
    logic [W-1:0]   d;
    bit             uns;
    logic [2*W:0]   r;

    repeat (2) @(posedge clock);
    #1;
    checking = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_zout", zout, 64'd0);
    clear = 1'b1;

    // pin the reference model itself
    check("model_18_4", ref_div(32'd18, 32'd4, 1'b0), {1'b0, 64'h00000002_00000004});
    check("model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b0), {1'b0, 64'h00000000_80000000});

    lit_div("div_18_4_poke", 32'h12, 32'h4, 1'b0, 1'b0, 5, 64'h00000002_00000004, 1'b0);
    lit_div("neg7_2", -32'sd7, 32'd2, 1'b0, 1'b0, -1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    lit_div("b2b_7_neg2", 32'd7, -32'sd2, 1'b0, 1'b1, -1, 64'h00000001_FFFFFFFD, 1'b0);
    lit_div("b2b_neg7_neg2", -32'sd7, -32'sd2, 1'b0, 1'b1, -1, 64'hFFFFFFFF_00000003, 1'b0);
    lit_div("div_zero", 32'd100, 32'd0, 1'b0, 1'b0, -1, 64'h00000064_FFFFFFFF, 1'b1);
    lit_div("after_zero", 32'd9, 32'd3, 1'b0, 1'b0, -1, 64'h00000000_00000003, 1'b0);
    lit_div("overflow", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, -1, 64'h00000000_80000000, 1'b0);
`ifdef DIV_UNSIGNED_SEL_EN
    lit_div("uns_sel", 32'hFFFFFFFE, 32'd2, 1'b1, 1'b0, -1, 64'h00000000_7FFFFFFF, 1'b0);
    lit_div("sgn_sel", 32'hFFFFFFFE, 32'd2, 1'b0, 1'b0, -1, 64'h00000000_FFFFFFFF, 1'b0);
`endif

    // abort mid-divide
    @(posedge clock);
    #1;
    start = 1'b1;
    dividend = 32'd1000;
    divisor = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    clear = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_zout", zout, 64'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    // randomized divides, mixing back-to-back and idle gaps
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; d = '0; end
        1:       begin a = W'($urandom_range(0, 200)) - 32'd100; d = W'($urandom_range(1, 20)) - 32'd10; end
        2:       begin a = 32'h80000000; d = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom; end
        default: begin a = $urandom; d = $urandom >> $urandom_range(0, 31); end
      endcase
`ifdef DIV_UNSIGNED_SEL_EN
      uns = 1'($urandom_range(0, 1));
`else
      uns = 1'b0;
`endif
      r = ref_div(a, d, uns);
      run_div(a, d, uns, 1'($urandom_range(0, 1)), -1, z, f, lat);
      check("rand_zout", z, r[2*W-1:0]);
      check("rand_dbz", 64'(f), 64'(r[2*W]));
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
